// File: rtl/tcp_rx_seg_proc.sv
// tcp_rx_seg_proc: receive-side per-segment TCP protocol engine.
// Reads RX/TX flow state, advances it, writes back, commits payload, schedules ACK.
module tcp_rx_seg_proc #(
   parameter int FLOWID_W = 8,
   parameter int SEQ_W    = 32,
   parameter int WIN_W    = 16,
   parameter int LEN_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rx_seg_val,
   input  logic [FLOWID_W-1:0]        rx_seg_flowid,
   input  logic [SEQ_W-1:0]           rx_seg_seq_num,
   input  logic [SEQ_W-1:0]           rx_seg_ack_num,
   input  logic                       rx_seg_ack_flag,
   input  logic [WIN_W-1:0]           rx_seg_window,
   input  logic [LEN_W-1:0]           rx_seg_payload_len,
   output logic                       rx_seg_rdy,
   output logic                       rx_state_rd_req_val,
   output logic [FLOWID_W-1:0]        rx_state_rd_req_addr,
   input  logic                       rx_state_rd_req_rdy,
   input  logic                       rx_state_rd_resp_val,
   input  logic [SEQ_W-1:0]           rx_state_rd_resp_data,
   output logic                       rx_state_rd_resp_rdy,
   output logic                       tx_state_rd_req_val,
   output logic [FLOWID_W-1:0]        tx_state_rd_req_addr,
   input  logic                       tx_state_rd_req_rdy,
   input  logic                       tx_state_rd_resp_val,
   input  logic [2*SEQ_W+WIN_W-1:0]   tx_state_rd_resp_data,
   output logic                       tx_state_rd_resp_rdy,
   output logic                       rx_state_wr_req_val,
   output logic [FLOWID_W-1:0]        rx_state_wr_req_addr,
   output logic [SEQ_W-1:0]           rx_state_wr_req_data,
   input  logic                       rx_state_wr_req_rdy,
   output logic                       tx_state_wr_req_val,
   output logic [FLOWID_W-1:0]        tx_state_wr_req_addr,
   output logic [2*SEQ_W+WIN_W-1:0]   tx_state_wr_req_data,
   input  logic                       tx_state_wr_req_rdy,
   output logic                       rx_commit_val,
   output logic [FLOWID_W-1:0]        rx_commit_flowid,
   output logic [SEQ_W-1:0]           rx_commit_seq,
   output logic [LEN_W-1:0]           rx_commit_len,
   input  logic                       rx_commit_rdy,
   output logic                       sched_cmd_val,
   output logic [FLOWID_W-1:0]        sched_cmd_flowid,
   input  logic                       sched_cmd_rdy
);

   localparam int TXS_W = 2*SEQ_W + WIN_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_RESP,
      S_CALC,
      S_WR,
      S_SCHED
   } state_e;

   state_e state_q, state_d;

   logic [FLOWID_W-1:0] flowid_q, flowid_d;
   logic [SEQ_W-1:0]    seq_q, seq_d;
   logic [SEQ_W-1:0]    ack_q, ack_d;
   logic                ackf_q, ackf_d;
   logic [WIN_W-1:0]    win_q, win_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [SEQ_W-1:0]    exp_q, exp_d;
   logic [SEQ_W-1:0]    new_exp_q, new_exp_d;
   logic [SEQ_W-1:0]    acked_q, acked_d;
   logic [SEQ_W-1:0]    nxt_q, nxt_d;
   logic [WIN_W-1:0]    pwin_q, pwin_d;
   logic                in_order_q, in_order_d;
   logic                need_ack_q, need_ack_d;
   // bit0: rx channel, bit1: tx channel, bit2: commit channel
   logic [2:0]          done_q, done_d;

   logic                in_order;
   logic                ack_ok;
   logic [SEQ_W-1:0]    ack_adv;
   logic [SEQ_W-1:0]    ack_room;
   logic [SEQ_W-1:0]    len_ext;

   // sequence comparisons are two's-complement differences so they survive wrap
   assign len_ext  = {{(SEQ_W-LEN_W){1'b0}}, len_q};
   assign in_order = (seq_q == exp_q) && (len_q != '0);
   assign ack_adv  = ack_q - acked_q;
   assign ack_room = nxt_q - ack_q;
   assign ack_ok   = ackf_q
                   && !ack_adv[SEQ_W-1] && (ack_adv != '0)
                   && !ack_room[SEQ_W-1];

   // handshake-facing outputs are gated by reset so nothing leaks before the first edge
   assign rx_seg_rdy           = rst && (state_q == S_IDLE);
   assign rx_state_rd_req_val  = rst && (state_q == S_RD_REQ) && !done_q[0];
   assign tx_state_rd_req_val  = rst && (state_q == S_RD_REQ) && !done_q[1];
   assign rx_state_rd_resp_rdy = rst && (state_q == S_RD_RESP) && !done_q[0];
   assign tx_state_rd_resp_rdy = rst && (state_q == S_RD_RESP) && !done_q[1];
   assign rx_state_wr_req_val  = rst && (state_q == S_WR) && !done_q[0];
   assign tx_state_wr_req_val  = rst && (state_q == S_WR) && !done_q[1];
   assign rx_commit_val        = rst && (state_q == S_WR) && !done_q[2];
   assign sched_cmd_val        = rst && (state_q == S_SCHED);

   assign rx_state_rd_req_addr = flowid_q;
   assign tx_state_rd_req_addr = flowid_q;
   assign rx_state_wr_req_addr = flowid_q;
   assign tx_state_wr_req_addr = flowid_q;
   assign rx_state_wr_req_data = new_exp_q;
   assign tx_state_wr_req_data = {acked_q, nxt_q, pwin_q};
   assign rx_commit_flowid     = flowid_q;
   assign rx_commit_seq        = exp_q;
   assign rx_commit_len        = len_q;
   assign sched_cmd_flowid     = flowid_q;

   // next-state and datapath updates for the segment sequencer
   always_comb begin
      state_d    = state_q;
      flowid_d   = flowid_q;
      seq_d      = seq_q;
      ack_d      = ack_q;
      ackf_d     = ackf_q;
      win_d      = win_q;
      len_d      = len_q;
      exp_d      = exp_q;
      new_exp_d  = new_exp_q;
      acked_d    = acked_q;
      nxt_d      = nxt_q;
      pwin_d     = pwin_q;
      in_order_d = in_order_q;
      need_ack_d = need_ack_q;
      done_d     = done_q;
      unique case (state_q)
         S_IDLE: begin
            if (rx_seg_val) begin
               flowid_d = rx_seg_flowid;
               seq_d    = rx_seg_seq_num;
               ack_d    = rx_seg_ack_num;
               ackf_d   = rx_seg_ack_flag;
               win_d    = rx_seg_window;
               len_d    = rx_seg_payload_len;
               done_d   = '0;
               state_d  = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (rx_state_rd_req_val && rx_state_rd_req_rdy) done_d[0] = 1'b1;
            if (tx_state_rd_req_val && tx_state_rd_req_rdy) done_d[1] = 1'b1;
            if (done_d[0] && done_d[1]) begin
               done_d  = '0;
               state_d = S_RD_RESP;
            end
         end
         S_RD_RESP: begin
            if (rx_state_rd_resp_val && rx_state_rd_resp_rdy) begin
               exp_d     = rx_state_rd_resp_data;
               done_d[0] = 1'b1;
            end
            if (tx_state_rd_resp_val && tx_state_rd_resp_rdy) begin
               acked_d   = tx_state_rd_resp_data[TXS_W-1 -: SEQ_W];
               nxt_d     = tx_state_rd_resp_data[WIN_W +: SEQ_W];
               pwin_d    = tx_state_rd_resp_data[WIN_W-1:0];
               done_d[1] = 1'b1;
            end
            if (done_d[0] && done_d[1]) begin
               done_d  = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            new_exp_d  = in_order ? exp_q + len_ext : exp_q;
            if (ack_ok) begin
               acked_d = ack_q;
               pwin_d  = win_q;
            end
            in_order_d = in_order;
            need_ack_d = (len_q != '0);
            done_d     = {~in_order, 2'b00};
            state_d    = S_WR;
         end
         S_WR: begin
            if (rx_state_wr_req_val && rx_state_wr_req_rdy) done_d[0] = 1'b1;
            if (tx_state_wr_req_val && tx_state_wr_req_rdy) done_d[1] = 1'b1;
            if (rx_commit_val && rx_commit_rdy) done_d[2] = 1'b1;
            if (&done_d) begin
               done_d  = '0;
               state_d = need_ack_q ? S_SCHED : S_IDLE;
            end
         end
         S_SCHED: begin
            if (sched_cmd_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         flowid_q   <= '0;
         seq_q      <= '0;
         ack_q      <= '0;
         ackf_q     <= 1'b0;
         win_q      <= '0;
         len_q      <= '0;
         exp_q      <= '0;
         new_exp_q  <= '0;
         acked_q    <= '0;
         nxt_q      <= '0;
         pwin_q     <= '0;
         in_order_q <= 1'b0;
         need_ack_q <= 1'b0;
         done_q     <= '0;
      end else begin
         state_q    <= state_d;
         flowid_q   <= flowid_d;
         seq_q      <= seq_d;
         ack_q      <= ack_d;
         ackf_q     <= ackf_d;
         win_q      <= win_d;
         len_q      <= len_d;
         exp_q      <= exp_d;
         new_exp_q  <= new_exp_d;
         acked_q    <= acked_d;
         nxt_q      <= nxt_d;
         pwin_q     <= pwin_d;
         in_order_q <= in_order_d;
         need_ack_q <= need_ack_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_tcp_rx_seg_proc.sv
// tb_tcp_rx_seg_proc: directed bench with a per-segment reference model.
// The bench plays the state memories and downstream consumers.
module tb_tcp_rx_seg_proc;

   localparam int FW = 8;
   localparam int SW = 32;
   localparam int WW = 16;
   localparam int LW = 16;
   localparam int TW = 2*SW+WW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx_seg_val = 1'b0;
   logic [FW-1:0] rx_seg_flowid = '0;
   logic [SW-1:0] rx_seg_seq_num = '0;
   logic [SW-1:0] rx_seg_ack_num = '0;
   logic          rx_seg_ack_flag = 1'b0;
   logic [WW-1:0] rx_seg_window = '0;
   logic [LW-1:0] rx_seg_payload_len = '0;
   logic          rx_seg_rdy;
   logic          rx_state_rd_req_val;
   logic [FW-1:0] rx_state_rd_req_addr;
   logic          rx_state_rd_req_rdy = 1'b1;
   logic          rx_state_rd_resp_val = 1'b0;
   logic [SW-1:0] rx_state_rd_resp_data = '0;
   logic          rx_state_rd_resp_rdy;
   logic          tx_state_rd_req_val;
   logic [FW-1:0] tx_state_rd_req_addr;
   logic          tx_state_rd_req_rdy = 1'b1;
   logic          tx_state_rd_resp_val = 1'b0;
   logic [TW-1:0] tx_state_rd_resp_data = '0;
   logic          tx_state_rd_resp_rdy;
   logic          rx_state_wr_req_val;
   logic [FW-1:0] rx_state_wr_req_addr;
   logic [SW-1:0] rx_state_wr_req_data;
   logic          rx_state_wr_req_rdy = 1'b1;
   logic          tx_state_wr_req_val;
   logic [FW-1:0] tx_state_wr_req_addr;
   logic [TW-1:0] tx_state_wr_req_data;
   logic          tx_state_wr_req_rdy = 1'b1;
   logic          rx_commit_val;
   logic [FW-1:0] rx_commit_flowid;
   logic [SW-1:0] rx_commit_seq;
   logic [LW-1:0] rx_commit_len;
   logic          rx_commit_rdy = 1'b1;
   logic          sched_cmd_val;
   logic [FW-1:0] sched_cmd_flowid;
   logic          sched_cmd_rdy = 1'b1;

   tcp_rx_seg_proc #(
      .FLOWID_W(FW), .SEQ_W(SW), .WIN_W(WW), .LEN_W(LW)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_seg_val(rx_seg_val), .rx_seg_flowid(rx_seg_flowid),
      .rx_seg_seq_num(rx_seg_seq_num), .rx_seg_ack_num(rx_seg_ack_num),
      .rx_seg_ack_flag(rx_seg_ack_flag), .rx_seg_window(rx_seg_window),
      .rx_seg_payload_len(rx_seg_payload_len), .rx_seg_rdy(rx_seg_rdy),
      .rx_state_rd_req_val(rx_state_rd_req_val),
      .rx_state_rd_req_addr(rx_state_rd_req_addr),
      .rx_state_rd_req_rdy(rx_state_rd_req_rdy),
      .rx_state_rd_resp_val(rx_state_rd_resp_val),
      .rx_state_rd_resp_data(rx_state_rd_resp_data),
      .rx_state_rd_resp_rdy(rx_state_rd_resp_rdy),
      .tx_state_rd_req_val(tx_state_rd_req_val),
      .tx_state_rd_req_addr(tx_state_rd_req_addr),
      .tx_state_rd_req_rdy(tx_state_rd_req_rdy),
      .tx_state_rd_resp_val(tx_state_rd_resp_val),
      .tx_state_rd_resp_data(tx_state_rd_resp_data),
      .tx_state_rd_resp_rdy(tx_state_rd_resp_rdy),
      .rx_state_wr_req_val(rx_state_wr_req_val),
      .rx_state_wr_req_addr(rx_state_wr_req_addr),
      .rx_state_wr_req_data(rx_state_wr_req_data),
      .rx_state_wr_req_rdy(rx_state_wr_req_rdy),
      .tx_state_wr_req_val(tx_state_wr_req_val),
      .tx_state_wr_req_addr(tx_state_wr_req_addr),
      .tx_state_wr_req_data(tx_state_wr_req_data),
      .tx_state_wr_req_rdy(tx_state_wr_req_rdy),
      .rx_commit_val(rx_commit_val), .rx_commit_flowid(rx_commit_flowid),
      .rx_commit_seq(rx_commit_seq), .rx_commit_len(rx_commit_len),
      .rx_commit_rdy(rx_commit_rdy),
      .sched_cmd_val(sched_cmd_val), .sched_cmd_flowid(sched_cmd_flowid),
      .sched_cmd_rdy(sched_cmd_rdy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // expected effects of one segment
   typedef struct {
      logic [SW-1:0] rx_new;
      logic [TW-1:0] tx_new;
      bit            commit;
      bit            sched;
   } exp_t;

   function automatic exp_t model(input logic [SW-1:0] seq, ack,
                                  input bit flag, input logic [WW-1:0] win,
                                  input logic [LW-1:0] len,
                                  input logic [SW-1:0] exps, acked, nxt,
                                  input logic [WW-1:0] pwin);
      exp_t r;
      int   fwd, room;
      bit   ok;
      fwd  = int'(ack - acked);
      room = int'(nxt - ack);
      ok   = flag && (fwd > 0) && (room >= 0);
      r.commit = (seq == exps) && (len != 0);
      r.rx_new = r.commit ? exps + SW'(len) : exps;
      r.tx_new = ok ? {ack, nxt, win} : {acked, nxt, pwin};
      r.sched  = (len != 0);
      return r;
   endfunction

   exp_t          em;
   logic [FW-1:0] e_flow;
   logic [SW-1:0] e_exps;
   logic [LW-1:0] e_len;

   int n_rxrd, n_txrd, n_rxwr, n_txwr, n_cm, n_sc, n_anyval;
   logic [SW-1:0] cap_rxwr;
   logic [TW-1:0] cap_txwr;
   logic [SW-1:0] cap_cmseq;

   bit st_rxwr, st_txwr, st_cm, st_sc;
   logic [SW-1:0] pv_rxwr;
   logic [TW-1:0] pv_txwr;
   logic [SW-1:0] pv_cm;

   // compare process: checks every meaningful output against the model
   always @(negedge clk) begin
      if (!rst) begin
         st_rxwr = 0; st_txwr = 0; st_cm = 0; st_sc = 0;
      end else begin
         if (rx_state_wr_req_val || tx_state_wr_req_val ||
             rx_commit_val || sched_cmd_val) n_anyval++;
         if (rx_state_rd_req_val) begin
            check("rd_rx_addr", rx_state_rd_req_addr, e_flow);
            if (rx_state_rd_req_rdy) n_rxrd++;
         end
         if (tx_state_rd_req_val) begin
            check("rd_tx_addr", tx_state_rd_req_addr, e_flow);
            if (tx_state_rd_req_rdy) n_txrd++;
         end
         if (st_rxwr) check("rxwr_hold", {rx_state_wr_req_val, rx_state_wr_req_data},
                            {1'b1, pv_rxwr});
         if (st_txwr) check("txwr_hold", {tx_state_wr_req_val, tx_state_wr_req_data},
                            {1'b1, pv_txwr});
         if (st_cm) check("commit_hold", {rx_commit_val, rx_commit_seq}, {1'b1, pv_cm});
         if (st_sc) check("sched_hold", sched_cmd_val, 1'b1);
         if (rx_state_wr_req_val) begin
            check("rxwr", {rx_state_wr_req_addr, rx_state_wr_req_data},
                  {e_flow, em.rx_new});
            if (rx_state_wr_req_rdy) begin n_rxwr++; cap_rxwr = rx_state_wr_req_data; end
         end
         if (tx_state_wr_req_val) begin
            check("txwr", {tx_state_wr_req_addr, tx_state_wr_req_data},
                  {e_flow, em.tx_new});
            if (tx_state_wr_req_rdy) begin n_txwr++; cap_txwr = tx_state_wr_req_data; end
         end
         if (rx_commit_val) begin
            check("commit", {rx_commit_flowid, rx_commit_seq, rx_commit_len},
                  {e_flow, e_exps, e_len});
            if (rx_commit_rdy) begin n_cm++; cap_cmseq = rx_commit_seq; end
         end
         if (sched_cmd_val) begin
            check("sched", sched_cmd_flowid, e_flow);
            if (sched_cmd_rdy) n_sc++;
         end
         st_rxwr = rx_state_wr_req_val && !rx_state_wr_req_rdy;
         st_txwr = tx_state_wr_req_val && !tx_state_wr_req_rdy;
         st_cm   = rx_commit_val && !rx_commit_rdy;
         st_sc   = sched_cmd_val && !sched_cmd_rdy;
         pv_rxwr = rx_state_wr_req_data;
         pv_txwr = tx_state_wr_req_data;
         pv_cm   = rx_commit_seq;
      end
   end

   task automatic clr_counts();
      n_rxrd = 0; n_txrd = 0; n_rxwr = 0; n_txwr = 0;
      n_cm = 0; n_sc = 0; n_anyval = 0;
   endtask

   task automatic send(input logic [FW-1:0] fl, input logic [SW-1:0] seq, ack,
                       input bit flag, input logic [WW-1:0] win,
                       input logic [LW-1:0] len);
      int t;
      @(posedge clk) #1;
      rx_seg_val = 1; rx_seg_flowid = fl; rx_seg_seq_num = seq;
      rx_seg_ack_num = ack; rx_seg_ack_flag = flag;
      rx_seg_window = win; rx_seg_payload_len = len;
      t = 0;
      while (!rx_seg_rdy && t < 20) begin @(posedge clk) #1; t++; end
      if (t >= 20) check("accept_timeout", 0, 1);
      @(posedge clk) #1;
      rx_seg_val = 0;
   endtask

   task automatic run(input string nm, input logic [FW-1:0] fl,
                      input logic [SW-1:0] seq, ack, input bit flag,
                      input logic [WW-1:0] win, input logic [LW-1:0] len,
                      input logic [SW-1:0] exps, acked, nxt,
                      input logic [WW-1:0] pwin,
                      input int rxdly, txdly, hold, explat);
      int lat;
      em = model(seq, ack, flag, win, len, exps, acked, nxt, pwin);
      e_flow = fl; e_exps = exps; e_len = len;
      clr_counts();
      rx_state_wr_req_rdy = (hold == 0);
      tx_state_wr_req_rdy = (hold == 0);
      rx_commit_rdy       = (hold == 0);
      sched_cmd_rdy       = (hold == 0);
      send(fl, seq, ack, flag, win, len);
      lat = 0;
      fork
         begin
            int t = 0;
            while (t < 50) begin @(negedge clk); if (rx_state_rd_req_val) break; t++; end
            @(posedge clk);
            repeat (rxdly) @(posedge clk);
            #1 rx_state_rd_resp_val = 1; rx_state_rd_resp_data = exps;
            t = 0;
            while (t < 50) begin @(negedge clk); if (rx_state_rd_resp_rdy) break; t++; end
            @(posedge clk) #1 rx_state_rd_resp_val = 0;
         end
         begin
            int t = 0;
            while (t < 50) begin @(negedge clk); if (tx_state_rd_req_val) break; t++; end
            @(posedge clk);
            repeat (txdly) @(posedge clk);
            #1 tx_state_rd_resp_val = 1; tx_state_rd_resp_data = {acked, nxt, pwin};
            t = 0;
            while (t < 50) begin @(negedge clk); if (tx_state_rd_resp_rdy) break; t++; end
            @(posedge clk) #1 tx_state_rd_resp_val = 0;
         end
         begin
            if (hold > 0) begin
               int t = 0;
               while (t < 50) begin @(negedge clk); if (rx_state_wr_req_val) break; t++; end
               repeat (hold) @(posedge clk);
               #1;
               rx_state_wr_req_rdy = 1; tx_state_wr_req_rdy = 1;
               rx_commit_rdy = 1; sched_cmd_rdy = 1;
            end
         end
         begin
            while (!rx_seg_rdy && lat < 60) begin @(posedge clk) #1; lat++; end
         end
      join
      check({nm, "_latency"}, lat, explat);
      check({nm, "_n_rd"}, {n_rxrd[7:0], n_txrd[7:0]}, 16'h0101);
      check({nm, "_n_wr"}, {n_rxwr[7:0], n_txwr[7:0]}, 16'h0101);
      check({nm, "_n_commit"}, n_cm, em.commit ? 1 : 0);
      check({nm, "_n_sched"}, n_sc, em.sched ? 1 : 0);
      rx_state_wr_req_rdy = 1; tx_state_wr_req_rdy = 1;
      rx_commit_rdy = 1; sched_cmd_rdy = 1;
   endtask

   initial begin
      clr_counts();
      e_flow = '0; e_exps = '0; e_len = '0;
      em = model(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // reset held three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rdy", rx_seg_rdy, 1'b0);
      check("rst_vals", {rx_state_rd_req_val, tx_state_rd_req_val,
                         rx_state_rd_resp_rdy, tx_state_rd_resp_rdy,
                         rx_state_wr_req_val, tx_state_wr_req_val,
                         rx_commit_val, sched_cmd_val}, 8'h00);
      check("rst_data", {rx_state_wr_req_data, tx_state_wr_req_data,
                         rx_commit_len, sched_cmd_flowid}, '0);
      @(posedge clk) #1 rst = 1;
      @(negedge clk);
      check("post_rst_rdy", rx_seg_rdy, 1'b1);
      check("post_rst_vals", {rx_state_rd_req_val, tx_state_rd_req_val,
                              rx_state_wr_req_val, tx_state_wr_req_val,
                              rx_commit_val, sched_cmd_val}, 6'h00);

      // in-order payload, no ACK flag
      run("inorder", 8'd5, 1000, 0, 0, 16'h0, 100, 1000, 500, 900, 16'h1000, 0, 0, 0, 5);
      check("lit_inorder_rx", cap_rxwr, 32'd1100);
      check("lit_inorder_seq", cap_cmseq, 32'd1000);
      check("lit_inorder_tx", cap_txwr, {32'd500, 32'd900, 16'h1000});

      // out-of-order payload: dropped but ACK scheduled
      run("ooo", 8'd7, 1200, 0, 0, 16'h0, 50, 1000, 500, 900, 16'h1000, 0, 0, 0, 5);
      check("lit_ooo_rx", cap_rxwr, 32'd1000);

      // pure ACK advance
      run("ackadv", 8'd9, 2000, 700, 1, 16'h4000, 0, 2000, 500, 900, 16'h0100, 0, 0, 0, 4);
      check("lit_ackadv_tx", cap_txwr, {32'd700, 32'd900, 16'h4000});

      // ACK beyond next_send ignored
      run("ackbad", 8'd9, 2000, 950, 1, 16'h4000, 0, 2000, 500, 900, 16'h0100, 1, 0, 0, 5);
      check("lit_ackbad_tx", cap_txwr, {32'd500, 32'd900, 16'h0100});

      // ACK exactly at next_send accepted; ACK equal to acked ignored
      run("ackedge", 8'd2, 10, 900, 1, 16'h0777, 0, 10, 500, 900, 16'h0100, 0, 2, 0, 6);
      check("lit_ackedge_tx", cap_txwr, {32'd900, 32'd900, 16'h0777});
      run("ackdup", 8'd2, 10, 500, 1, 16'h0777, 0, 10, 500, 900, 16'h0100, 0, 0, 0, 4);
      check("lit_ackdup_tx", cap_txwr, {32'd500, 32'd900, 16'h0100});

      // wrap-around of both sequence space and ack comparison
      run("wrap", 8'd255, 32'hFFFF_FFF0, 32'h80, 1, 16'h2222, 16'h20,
          32'hFFFF_FFF0, 32'hFFFF_FF00, 32'h100, 16'h0100, 0, 0, 0, 5);
      check("lit_wrap_rx", cap_rxwr, 32'h10);
      check("lit_wrap_tx", cap_txwr, {32'h80, 32'h100, 16'h2222});

      // backpressure: tx responds first, rx 3 cycles later, writes held 4 cycles
      run("bp", 8'd3, 3000, 1500, 1, 16'h0800, 64, 3000, 1000, 2000, 16'h0200, 3, 0, 4, 12);
      check("lit_bp_rx", cap_rxwr, 32'd3064);
      check("lit_bp_tx", cap_txwr, {32'd1500, 32'd2000, 16'h0800});

      // reset mid-operation abandons the segment
      e_flow = 8'd4;
      clr_counts();
      send(8'd4, 100, 0, 0, 16'h0, 10);
      @(posedge clk) #1;
      rst = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      clr_counts();
      rx_state_rd_resp_val = 1; tx_state_rd_resp_val = 1;
      repeat (8) @(posedge clk);
      #1 rx_state_rd_resp_val = 0; tx_state_rd_resp_val = 0;
      @(negedge clk);
      check("midrst_no_writes", n_anyval, 0);
      check("midrst_idle", rx_seg_rdy, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
